inst_prefetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the microprocessor's IF stage. It drives the instruction-memory request/acknowledge handshake, prefetches sequential words into a small FIFO, and presents them to the core through a valid/ready interface. A branch/redirect input flushes the queue and restarts fetching at a new word address. Outstanding memory reads are completed and their data discarded.

---
 rtl/inst_prefetch_queue.sv | 147 ++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch front end: issues sequential word fetches over a req/ack
// handshake, buffers returned words in a small FIFO and presents them valid/ready.
module inst_prefetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 30,
  parameter  int DW    = 32,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic          inst_valid,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_addr,
  input  logic          inst_ready,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] level_next;
  logic          push;
  logic          pop;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  // A redirect suppresses both queue ports: the flush wins over any pop or push.
  assign inst_valid = (level_q != '0);
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign push       = (state_q == REQ) & mem_ack & ~redirect_valid;
  assign level_next = level_q + LW'(push) - LW'(pop);

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q + PW'(pop);
    tail_d     = tail_q + PW'(push);
    level_d    = level_next;

    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
      head_d     = '0;
      tail_d     = '0;
      level_d    = '0;
    end

    case (state_q)
      IDLE: begin
        if (en && (redirect_valid || (level_q < DEPTH_L))) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_valid ? redirect_addr : fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          // Without an ack the old read is still in flight and must be drained.
          if (!mem_ack) begin
            state_d = DISCARD;
          end else if (en) begin
            mem_addr_d = redirect_addr;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end else if (mem_ack) begin
          fetch_pc_d = mem_addr_q + AW'(1);
          if (en && (level_next < DEPTH_L)) begin
            mem_addr_d = mem_addr_q + AW'(1);
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          if (en) begin
            state_d    = REQ;
            mem_addr_d = fetch_pc_d;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= mem_addr_q;
      data_mem[tail_q] <= mem_data;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign inst_data = data_mem[head_q];
  assign inst_addr = addr_mem[head_q];
  assign level     = level_q;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue: a queue-based reference model of the
// fetch protocol predicts every output, cycle by cycle, from the driven stimulus.
module tb_inst_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          redirectValid;
  logic [AW-1:0] redirectAddr;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memAck;
  logic [DW-1:0] memData;
  logic          instValid;
  logic [DW-1:0] instData;
  logic [AW-1:0] instAddr;
  logic          instReady;
  logic [2:0]    level;

  int checkCount = 0;
  int failCount  = 0;

  // Stimulus knobs, percentages per cycle.
  int  enPct, ackPct, readyPct, redirPct, spuriousPct;
  bit  lastRedir = 1'b0;

  // Reference model: request bookkeeping plus a plain queue of fetched words.
  bit            mReq;
  bit            mDisc;
  logic [AW-1:0] mAddr;
  logic [AW-1:0] mPc;
  logic [AW-1:0] qAddr [$];
  logic [DW-1:0] qData [$];

  inst_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirectValid),
    .redirect_addr  (redirectAddr),
    .mem_req        (memReq),
    .mem_addr       (memAddr),
    .mem_ack        (memAck),
    .mem_data       (memData),
    .inst_valid     (instValid),
    .inst_data      (instData),
    .inst_addr      (instAddr),
    .inst_ready     (instReady),
    .level          (level)
  );

  always #5 clk = ~clk;

  // Memory contents derived from the word address so every word is recognisable.
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return {a, 2'b00} ^ 32'hA5C3_1E77;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mReq  = 1'b0;
    mDisc = 1'b0;
    mAddr = '0;
    mPc   = '0;
    qAddr.delete();
    qData.delete();
  endtask

  // Randomize all inputs for the coming edge; the memory answers the live request.
  task automatic applyStimulus();
    en        = ($urandom_range(0, 99) < enPct);
    instReady = ($urandom_range(0, 99) < readyPct);
    redirectValid = !lastRedir && ($urandom_range(0, 99) < redirPct);
    if ($urandom_range(0, 3) == 0)
      redirectAddr = 30'h3FFF_FFFF - AW'($urandom_range(0, 2));
    else
      redirectAddr = AW'($urandom);
    lastRedir = redirectValid;
    if (memReq) begin
      memAck  = ($urandom_range(0, 99) < ackPct);
      memData = memWord(memAddr);
    end else begin
      memAck  = ($urandom_range(0, 99) < spuriousPct);
      memData = $urandom;
    end
  endtask

  task automatic compareAll();
    checkOutput("mem_req", {31'd0, memReq}, {31'd0, mReq});
    if (mReq) checkOutput("mem_addr", {2'b00, memAddr}, {2'b00, mAddr});
    checkOutput("level", {29'd0, level}, 32'(qAddr.size()));
    checkOutput("inst_valid", {31'd0, instValid}, {31'd0, (qAddr.size() != 0)});
    if (qAddr.size() != 0) begin
      checkOutput("inst_addr", {2'b00, instAddr}, {2'b00, qAddr[0]});
      checkOutput("inst_data", instData, qData[0]);
    end
  endtask

  // Advance the model by one clock edge using the values that were sampled there.
  task automatic updateModel();
    int sizeBefore;
    bit popNow;
    if (rst) begin
      modelReset();
      return;
    end
    sizeBefore = qAddr.size();
    popNow     = (sizeBefore != 0) && instReady;
    if (redirectValid) begin
      qAddr.delete();
      qData.delete();
      mPc = redirectAddr;
      if (mReq && !mDisc) begin
        if (!memAck) mDisc = 1'b1;
        else if (en) mAddr = redirectAddr;
        else mReq = 1'b0;
      end else if (mReq) begin
        if (memAck) begin
          mDisc = 1'b0;
          if (en) mAddr = redirectAddr;
          else mReq = 1'b0;
        end
      end else if (en) begin
        mReq  = 1'b1;
        mAddr = redirectAddr;
      end
    end else begin
      if (popNow) begin
        void'(qAddr.pop_front());
        void'(qData.pop_front());
      end
      if (mReq && !mDisc) begin
        if (memAck) begin
          qAddr.push_back(mAddr);
          qData.push_back(memData);
          mPc = AW'(mAddr + AW'(1));
          if (en && qAddr.size() < DEPTH) mAddr = AW'(mAddr + AW'(1));
          else mReq = 1'b0;
        end
      end else if (mReq) begin
        if (memAck) begin
          mDisc = 1'b0;
          if (en) mAddr = mPc;
          else mReq = 1'b0;
        end
      end else if (en && sizeBefore < DEPTH) begin
        mReq  = 1'b1;
        mAddr = mPc;
      end
    end
  endtask

  // One cycle: drive at the falling edge, check, then follow the rising edge.
  task automatic step(input bit forceRedir = 1'b0, input logic [AW-1:0] forceAddr = '0);
    applyStimulus();
    if (forceRedir) begin
      redirectValid = 1'b1;
      redirectAddr  = forceAddr;
      lastRedir     = 1'b1;
    end
    compareAll();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic setKnobs(input int e, input int a, input int r, input int d, input int s);
    enPct = e; ackPct = a; readyPct = r; redirPct = d; spuriousPct = s;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; redirectValid = 1'b0; redirectAddr = '0;
    memAck = 1'b0; memData = '0; instReady = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_mem_req", {31'd0, memReq}, 32'd0);
    checkOutput("reset_mem_addr", {2'b00, memAddr}, 32'd0);
    checkOutput("reset_inst_valid", {31'd0, instValid}, 32'd0);
    checkOutput("reset_level", {29'd0, level}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait memory with an always-ready core streams one word per cycle.
    setKnobs(100, 100, 100, 0, 0);
    for (int i = 0; i < 20; i++) step();

    // Stalled core fills the queue, then a single pop frees exactly one slot.
    setKnobs(100, 100, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("full_level", {29'd0, level}, DEPTH);
    checkOutput("full_mem_req", {31'd0, memReq}, 32'd0);
    setKnobs(100, 100, 100, 0, 0);
    step();
    setKnobs(100, 100, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();

    // Slow memory and a sometimes-busy core.
    setKnobs(100, 30, 60, 0, 0);
    for (int i = 0; i < 300; i++) step();

    // Redirect onto the last word address to exercise fetch address wraparound.
    setKnobs(100, 100, 100, 0, 0);
    step(1'b1, 30'h3FFF_FFFF);
    for (int i = 0; i < 6; i++) step();

    // Everything at once: redirects, enable toggling, stray acks, random latency.
    setKnobs(85, 40, 60, 6, 10);
    for (int i = 0; i < 2000; i++) step();
    setKnobs(60, 100, 50, 10, 20);
    for (int i = 0; i < 1000; i++) step();

    // Reset in the middle of an outstanding request must drop it immediately.
    setKnobs(100, 0, 0, 0, 0);
    for (int i = 0; i < 10 && !memReq; i++) step();
    checkOutput("reach_req", {31'd0, memReq}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mem_req", {31'd0, memReq}, 32'd0);
    checkOutput("async_rst_level", {29'd0, level}, 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    setKnobs(0, 0, 0, 0, 100);
    for (int i = 0; i < 3; i++) step();
    checkOutput("no_push_after_rst", {29'd0, level}, 32'd0);

    setKnobs(90, 50, 50, 5, 10);
    for (int i = 0; i < 300; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
